// File: rtl/hms_display_blink_pkg.sv
// Shared constants, segment table and FSM state type for the HMS display path.
package hms_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low gfedcba patterns for decimal digits 0..9.
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic {IDLE, CONV} state_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_BLANK;
    if (d <= 4'd9) s = SEG_TABLE[d];
    return s;
  endfunction

endpackage

// File: rtl/hms_display_blink_sseg_dec.sv
// One BCD digit to active-low 7-segment pattern; blank forces all segments off.
module sseg_dec
  import hms_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : bcd_to_seg(bcd);
  end

endmodule

// File: rtl/hms_display_blink.sv
// HMS display path: snapshot fields, serial double-dabble to BCD, blinking 7-seg digits.
// Build option: define HMS_LEADING_BLANK_EN to blank a field's tens digit when it is zero.
module hms_display_blink
  import hms_disp_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HZ   = 2,
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W    = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_FIELDS*FIELD_W-1:0]   vals,
  input  logic                            load,
  input  logic [$clog2(NUM_FIELDS+1)-1:0] edit_sel,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_FIELDS*14-1:0]        hex
);

  localparam int SEL_W = $clog2(NUM_FIELDS+1);
  localparam int FLD_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int CNT_W = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;
  localparam int HALF  = CLK_HZ / (2*BLINK_HZ);
  localparam int PRE_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int NDIG  = 2*NUM_FIELDS;
  localparam int BCD_W = 10;  // hundreds[1:0], tens, ones: covers 7-bit fields

  state_t                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [FLD_W-1:0]                   fld_q, fld_d;
  logic [NUM_FIELDS-1:0][FIELD_W-1:0] snap_q, snap_d;
  logic [FIELD_W-1:0]                 bin_q, bin_d;
  logic [BCD_W-1:0]                   bcd_q, bcd_d;
  logic [NUM_FIELDS-1:0][3:0]         ones_q, ones_d, tens_q, tens_d;
  logic [NUM_FIELDS-1:0]              over_q, over_d, tens_blank;
  logic [NDIG-1:0][6:0]               seg_q, seg_d, dec_seg, new_seg;
  logic                               done_q, done_d, commit;
  logic [SEL_W-1:0]                   sel_q, sel_d;
  logic [PRE_W-1:0]                   pre_q, pre_d;
  logic                               blank_q, blank_d;
  logic [BCD_W-1:0]                   bcd_adj;
  logic [BCD_W:0]                     bcd_sh;
  logic                               last_bit, last_fld;

  assign last_bit = (cnt_q == CNT_W'(FIELD_W-1));
  assign last_fld = (fld_q == FLD_W'(NUM_FIELDS-1));

  // One double-dabble step: add-3 on digits >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    bcd_sh = {bcd_adj, bin_q[FIELD_W-1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fld_d   = fld_q;
    snap_d  = snap_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    over_d  = over_q;
    done_d  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = CONV;
          snap_d  = vals;
          bin_d   = vals[FIELD_W-1:0];
          bcd_d   = '0;
          cnt_d   = '0;
          fld_d   = '0;
        end
      end
      CONV: begin
        bin_d = bin_q << 1;
        bcd_d = bcd_sh[BCD_W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          ones_d[fld_q] = bcd_sh[3:0];
          tens_d[fld_q] = bcd_sh[7:4];
          over_d[fld_q] = |bcd_sh[BCD_W:8];
          cnt_d = '0;
          bcd_d = '0;
          if (last_fld) begin
            state_d = IDLE;
            done_d  = 1'b1;
            commit  = 1'b1;
          end else begin
            fld_d = fld_q + 1'b1;
            bin_d = snap_q[fld_q + 1'b1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoders look at the next-state digits so the last field lands in the same commit edge.
  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_dec
`ifdef HMS_LEADING_BLANK_EN
    assign tens_blank[gi] = (tens_d[gi] == 4'd0);
`else
    assign tens_blank[gi] = 1'b0;
`endif
    sseg_dec u_ones (.bcd(ones_d[gi]), .blank(1'b0),           .seg(dec_seg[2*gi]));
    sseg_dec u_tens (.bcd(tens_d[gi]), .blank(tens_blank[gi]), .seg(dec_seg[2*gi+1]));
    assign new_seg[2*gi]   = over_d[gi] ? SEG_DASH : dec_seg[2*gi];
    assign new_seg[2*gi+1] = over_d[gi] ? SEG_DASH : dec_seg[2*gi+1];
  end

  always_comb begin
    seg_d = commit ? new_seg : seg_q;
  end

  always_comb begin
    sel_d   = edit_sel;
    pre_d   = pre_q;
    blank_d = blank_q;
    if (edit_sel != sel_q) begin
      pre_d   = '0;
      blank_d = 1'b0;
    end else if (pre_q == PRE_W'(HALF-1)) begin
      pre_d   = '0;
      blank_d = ~blank_q;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fld_q   <= '0;
      snap_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      over_q  <= '0;
      seg_q   <= {NDIG{SEG_BLANK}};
      done_q  <= 1'b0;
      sel_q   <= '0;
      pre_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fld_q   <= fld_d;
      snap_q  <= snap_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      over_q  <= over_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      pre_q   <= pre_d;
      blank_q <= blank_d;
    end
  end

  assign busy = (state_q == CONV);
  assign done = done_q;

  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_out
    logic fld_off;
    assign fld_off = blank_q && (sel_q == SEL_W'(gi+1));
    assign hex[14*gi +: 7]   = fld_off ? SEG_BLANK : seg_q[2*gi];
    assign hex[14*gi+7 +: 7] = fld_off ? SEG_BLANK : seg_q[2*gi+1];
  end

endmodule

// File: tb/tb_hms_display_blink.sv
// Bench for hms_display_blink: vector table plus scoreboard on done, blink and reset sequences.
module tb_hms_display_blink;

  localparam int NF = 3;
`ifdef HMS_LEADING_BLANK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  localparam logic [41:0] T2_HEX = {7'b0100100, 7'b0110000, (LB ? 7'h7F : 7'b1000000),
                                    7'b1111000, 7'b0010010, 7'b0010000};

  logic        clk = 1'b0, rst_n = 1'b0, load6 = 1'b0, load7 = 1'b0;
  logic [1:0]  edit_sel = 2'd0;
  logic [17:0] vals6 = '0;
  logic [20:0] vals7 = '0;
  logic        busy6, done6, busy7, done7;
  logic [41:0] hex6, hex7;
  int cyc = 0, errors = 0, checks = 0;

  typedef struct { logic [41:0] hex; int cyc; } exp_t;
  exp_t sb[$];
  exp_t got;

  typedef struct { int f0; int f1; int f2; logic [41:0] exp; } vec_t;
  vec_t vt[6];

  hms_display_blink #(.CLK_HZ(8), .BLINK_HZ(1), .NUM_FIELDS(NF), .FIELD_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .vals(vals6), .load(load6), .edit_sel(edit_sel),
    .busy(busy6), .done(done6), .hex(hex6));

  hms_display_blink #(.CLK_HZ(8), .BLINK_HZ(1), .NUM_FIELDS(NF), .FIELD_W(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .vals(vals7), .load(load7), .edit_sel(edit_sel),
    .busy(busy7), .done(done7), .hex(hex7));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [13:0] fld(input int v);
    if (v > 99) return {7'b0111111, 7'b0111111};
    return {(((v / 10) == 0) && LB) ? 7'h7F : seg(v / 10), seg(v % 10)};
  endfunction

  function automatic logic [41:0] model(input int f0, input int f1, input int f2);
    return {fld(f2), fld(f1), fld(f0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every done6 pulse must match the oldest pending load, value and cycle.
  always @(negedge clk) begin
    if (rst_n && done6) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 required no pending load (cycle %0d)", cyc);
      end else begin
        got = sb.pop_front();
        chk("done_hex", 64'(hex6), 64'(got.hex));
        chk("done_cycle", 64'(cyc), 64'(got.cyc));
        $display("done: hex=%h expected=%h cycle=%0d", hex6, got.hex, cyc);
      end
    end
  end

  task automatic do_load6(input int f0, input int f1, input int f2, input logic [41:0] e);
    @(negedge clk);
    vals6 = {6'(f2), 6'(f1), 6'(f0)};
    load6 = 1'b1;
    sb.push_back('{e, cyc + 19});
    @(negedge clk);
    load6 = 1'b0;
    chk("busy_after_load", 64'(busy6), 64'd1);
  endtask

  task automatic wait_done(input bit sel7, input int max);
    int n;
    n = 0;
    while (!(sel7 ? done7 : done6) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles required done (dut%0d)", max, sel7 ? 7 : 6);
    end
  endtask

  task automatic blink_run(input int sel, input int n);
    logic [41:0] e;
    @(negedge clk);
    edit_sel = 2'(sel);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      e = T2_HEX;
      if (sel != 0 && (((j - 1) / 4) % 2) == 1) e[14*(sel-1) +: 14] = '1;
      chk("blink_hex", 64'(hex6), 64'(e));
      $display("blink: sel=%0d step=%0d hex=%h", sel, j, hex6);
    end
  endtask

  initial begin
    int t0;
    vt[0] = '{59, 7, 23, T2_HEX};
    vt[1] = '{0, 0, 0, model(0, 0, 0)};
    vt[2] = '{63, 10, 9, model(63, 10, 9)};
    vt[3] = '{12, 34, 56, model(12, 34, 56)};
    vt[4] = '{45, 30, 5, model(45, 30, 5)};
    vt[5].f0 = int'($urandom_range(0, 63));
    vt[5].f1 = int'($urandom_range(0, 63));
    vt[5].f2 = int'($urandom_range(0, 63));
    vt[5].exp = model(vt[5].f0, vt[5].f1, vt[5].f2);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_hex", 64'(hex6), {22'd0, {42{1'b1}}});
    chk("reset_busy", 64'(busy6), 64'd0);
    chk("reset_done", 64'(done6), 64'd0);
    rst_n = 1'b1;

    // Vector table through the scoreboard
    for (int i = 0; i < 6; i++) begin
      do_load6(vt[i].f0, vt[i].f1, vt[i].f2, vt[i].exp);
      $display("load: vec=%0d vals=%0d,%0d,%0d", i, vt[i].f0, vt[i].f1, vt[i].f2);
      wait_done(1'b0, 40);
      @(negedge clk);
      chk("done_one_cycle", 64'(done6), 64'd0);
      chk("idle_after_done", 64'(busy6), 64'd0);
    end

    // Blink on minutes, hop to hours during the blank phase, then no blink
    do_load6(59, 7, 23, T2_HEX);
    wait_done(1'b0, 40);
    blink_run(2, 14);
    blink_run(3, 10);
    blink_run(0, 10);

    // Load mid-conversion ignored; load on the done cycle accepted
    do_load6(11, 22, 33, model(11, 22, 33));
    repeat (4) @(negedge clk);
    vals6 = {6'd1, 6'd2, 6'd3};
    load6 = 1'b1;
    @(negedge clk);
    load6 = 1'b0;
    wait_done(1'b0, 40);
    vals6 = {6'd44, 6'd8, 6'd50};
    load6 = 1'b1;
    sb.push_back('{model(50, 8, 44), cyc + 19});
    @(negedge clk);
    load6 = 1'b0;
    chk("busy_back_to_back", 64'(busy6), 64'd1);
    wait_done(1'b0, 40);

    // 7-bit fields: over-range dashes and 99
    for (int k = 0; k < 2; k++) begin
      int f0;
      f0 = (k == 0) ? 100 : 99;
      @(negedge clk);
      vals7 = {7'd45, 7'd120, 7'(f0)};
      load7 = 1'b1;
      t0 = cyc;
      @(negedge clk);
      load7 = 1'b0;
      wait_done(1'b1, 40);
      chk("w7_hex", 64'(hex7), 64'(model(f0, 120, 45)));
      chk("w7_latency", 64'(cyc - t0), 64'd22);
      $display("w7: field0=%0d hex=%h", f0, hex7);
    end

    // Asynchronous reset in the middle of a conversion
    do_load6(5, 6, 7, model(5, 6, 7));
    vals7 = {7'd1, 7'd2, 7'd3};
    load7 = 1'b1;
    @(negedge clk);
    load7 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midreset_hex6", 64'(hex6), {22'd0, {42{1'b1}}});
    chk("midreset_busy6", 64'(busy6), 64'd0);
    chk("midreset_done6", 64'(done6), 64'd0);
    chk("midreset_hex7", 64'(hex7), {22'd0, {42{1'b1}}});
    chk("midreset_busy7", 64'(busy7), 64'd0);
    $display("reset: mid-conversion hex6=%h hex7=%h", hex6, hex7);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_hex6", 64'(hex6), {22'd0, {42{1'b1}}});
    chk("post_reset_done7", 64'(done7), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
